// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage that sits directly behind the program counter.
// Issues one instruction-memory read per PC value, with at most one request
// in flight, and pulses pc_en to advance the PC. Returned words are tagged
// with their PC and buffered in a small FIFO that feeds decode.
//
// Handshake: decode takes the head entry in any cycle where instr_valid and
// instr_ready are both high. instr/instr_pc hold steady while
// instr_valid=1 and instr_ready=0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_en        run enable; when low no new request is issued
//   pc_addr         current PC value
//   pc_en           PC increment pulse, one per issued request
//   redirect        branch taken (PC overwritten in the same cycle)
//   imem_req        single-cycle read strobe; imem_addr valid with it
//   imem_addr       read address (pc_addr passed through)
//   imem_rvalid     read data valid, at least one cycle after imem_req
//   imem_rdata      read data
//   instr_valid     FIFO head valid
//   instr_ready     decode accepts the head entry
//   instr           head instruction
//   instr_pc        PC of the head instruction
//   dbg_state       FSM state (0=IDLE, 1=WAIT, 2=DISCARD)
//   dbg_count       FIFO occupancy
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic [ADDR_W-1:0]        pc_addr,
  output logic                     pc_en,
  input  logic                     redirect,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_rvalid,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic [ADDR_W-1:0]    r_req_pc;
  logic [INSTR_W-1:0]   r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]    r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Next-state and request decode. A response arriving together with a
  // redirect belongs to the old path, so it completes the request but is
  // not pushed.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_en && !redirect && (r_count < CNT_W'(DEPTH))) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_push      = !redirect;
          w_state_nxt = S_IDLE;
        end else if (redirect) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The stale response still has to drain before a new request.
        if (imem_rvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_req_pc <= pc_addr;
      end
    end
  end

  assign imem_req    = w_issue & ~rst;
  assign pc_en       = w_issue & ~rst;
  assign imem_addr   = pc_addr;
  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  assign instr       = r_mem_instr[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign dbg_state   = r_state;
  assign dbg_count   = r_count;

  // FIFO. A redirect flushes everything; a pop in that same cycle has
  // already been seen by decode, so nothing extra is needed for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= imem_rdata;
        r_mem_pc[r_wr_ptr]    <= r_req_pc;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a PC register and an instruction memory with
// configurable latency (mem[a] = 0x1000 + a) surround the DUT; directed
// scenario tasks check against hand-computed values.
module tb_fetch_unit;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, redirect, instr_ready, pc_en, imem_req;
  logic        imem_rvalid, instr_valid, m_rvalid, inj_rvalid, m_busy;
  logic [7:0]  pc, pc_rst_val, redir_target, imem_addr, instr_pc, m_addr;
  logic [15:0] imem_rdata, instr, m_rdata, inj_data;
  logic [1:0]  dbg_state, dbg_count;
  int          lat_cfg, m_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [23:0] got_q [$];
  logic [7:0]  req_q [$];
  int          pcen_q [$];

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_addr(pc), .pc_en(pc_en),
    .redirect(redirect), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // PC register upstream of the fetch stage
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) pc <= pc_rst_val;
    else if (redirect) pc <= redir_target;
    else if (pc_en) pc <= pc + 8'd1;
  end

  // Instruction memory, reset by the same rst
  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= 16'h1000 + {8'h00, m_addr};
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (imem_req) begin
      if (lat_cfg == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= 16'h1000 + {8'h00, imem_addr};
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= lat_cfg - 1;
        m_addr <= imem_addr;
      end
    end
  end

  assign imem_rvalid = m_rvalid | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_data : m_rdata;

  // Event log, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) got_q.push_back({instr, instr_pc});
      if (imem_req) req_q.push_back(imem_addr);
      if (pc_en) pcen_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] start_pc, input int lat, input logic rdy);
    fetch_en = 1'b0; redirect = 1'b0; inj_rvalid = 1'b0;
    instr_ready = rdy; lat_cfg = lat; pc_rst_val = start_pc;
    rst = 1'b1;
    tick(2);
    got_q.delete(); req_q.delete(); pcen_q.delete();
    rst = 1'b0;
    fetch_en = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1;
    tick(2);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if ({instr, instr_pc} !== 24'h0) begin errors++; $display("FAIL reset_head got=%h exp=000000", {instr, instr_pc}); end
    checks++; if ({dbg_state, dbg_count} !== 4'h0) begin errors++; $display("FAIL reset_state_count got=%h exp=0", {dbg_state, dbg_count}); end
  endtask

  task automatic test_straight();
    do_reset(8'h00, 1, 1'b1);
    tick(8);
    checks++; if (got_q.size() < 3 || got_q[0] !== 24'h100000 || got_q[1] !== 24'h100101 || got_q[2] !== 24'h100202) begin
      errors++; $display("FAIL straight_order n=%0d got0=%h got1=%h got2=%h exp=100000,100101,100202",
                         got_q.size(), got_q[0], got_q[1], got_q[2]); end
    checks++; if (pcen_q.size() < 3 || pcen_q[1] - pcen_q[0] != 2 || pcen_q[2] - pcen_q[1] != 2) begin
      errors++; $display("FAIL straight_pc_en_interval n=%0d got=%0d,%0d exp=2,2",
                         pcen_q.size(), pcen_q[1] - pcen_q[0], pcen_q[2] - pcen_q[1]); end
  endtask

  task automatic test_backpressure();
    do_reset(8'h00, 1, 1'b0);
    tick(8);
    checks++; if (dbg_count !== 2'd2 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_full got count=%0d valid=%b exp=2,1", dbg_count, instr_valid); end
    checks++; if (imem_req !== 1'b0 || pc !== 8'h02 || req_q.size() != 2) begin
      errors++; $display("FAIL bp_stall got req=%b pc=%h nreq=%0d exp=0,02,2", imem_req, pc, req_q.size()); end
    checks++; if ({instr, instr_pc} !== 24'h100000) begin errors++; $display("FAIL bp_head_hold got=%h exp=100000", {instr, instr_pc}); end
    instr_ready = 1'b1;
    tick(8);
    checks++; if (got_q.size() < 3 || got_q[0] !== 24'h100000 || got_q[1] !== 24'h100101 || got_q[2] !== 24'h100202) begin
      errors++; $display("FAIL bp_drain n=%0d got0=%h got1=%h got2=%h exp=100000,100101,100202",
                         got_q.size(), got_q[0], got_q[1], got_q[2]); end
    checks++; if (req_q.size() < 3 || req_q[2] !== 8'h02) begin errors++; $display("FAIL bp_resume_addr got=%h exp=02", req_q[2]); end
  endtask

  task automatic test_redirect_wait();
    do_reset(8'h05, 3, 1'b1);
    tick(1);
    redirect = 1'b1; redir_target = 8'h40;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL rw_quiet got req=%b pc_en=%b exp=0,0", imem_req, pc_en); end
    tick(1);
    redirect = 1'b0;
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rw_discard_state got=%0d exp=2", dbg_state); end
    tick(12);
    checks++; if (req_q.size() < 2 || req_q[0] !== 8'h05 || req_q[1] !== 8'h40) begin
      errors++; $display("FAIL rw_addrs n=%0d got=%h,%h exp=05,40", req_q.size(), req_q[0], req_q[1]); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 24'h104040) begin errors++; $display("FAIL rw_first_instr got=%h exp=104040", got_q[0]); end
  endtask

  task automatic test_redirect_coincident();
    // full FIFO in IDLE, stray rvalid + redirect, pop in the same cycle
    do_reset(8'h00, 1, 1'b0);
    tick(8);
    fetch_en = 1'b0;
    checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL rc_prefill got=%0d exp=2", dbg_count); end
    redirect = 1'b1; redir_target = 8'h80; inj_rvalid = 1'b1; inj_data = 16'hdead; instr_ready = 1'b1;
    tick(1);
    redirect = 1'b0; inj_rvalid = 1'b0;
    checks++; if (dbg_count !== 2'd0 || instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rc_flush got count=%0d valid=%b state=%0d exp=0,0,0", dbg_count, instr_valid, dbg_state); end
    tick(3);
    checks++; if (got_q.size() != 1 || got_q[0] !== 24'h100000) begin errors++; $display("FAIL rc_pops n=%0d got=%h exp=1,100000", got_q.size(), got_q[0]); end
    // rvalid and redirect together while in WAIT
    do_reset(8'h00, 3, 1'b1);
    tick(3);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL rcw_pre_state got=%0d exp=1", dbg_state); end
    redirect = 1'b1; redir_target = 8'h20;
    tick(1);
    redirect = 1'b0;
    checks++; if (dbg_state !== 2'd0 || dbg_count !== 2'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rcw_drop got state=%0d count=%0d valid=%b exp=0,0,0", dbg_state, dbg_count, instr_valid); end
    tick(8);
    checks++; if (got_q.size() < 1 || got_q[0] !== 24'h102020) begin errors++; $display("FAIL rcw_next got=%h exp=102020", got_q[0]); end
  endtask

  task automatic test_reset_mid_and_wrap();
    do_reset(8'h00, 3, 1'b0);
    tick(5);
    checks++; if (dbg_count !== 2'd1 || dbg_state !== 2'd1) begin errors++; $display("FAIL rm_pre got count=%0d state=%0d exp=1,1", dbg_count, dbg_state); end
    rst = 1'b1;
    tick(1);
    checks++; if ({imem_req, pc_en, instr_valid, dbg_state, dbg_count} !== 7'h0 || {instr, instr_pc} !== 24'h0) begin
      errors++; $display("FAIL rm_outputs got req=%b pc_en=%b valid=%b state=%0d count=%0d head=%h exp=all 0",
                         imem_req, pc_en, instr_valid, dbg_state, dbg_count, {instr, instr_pc}); end
    got_q.delete(); req_q.delete();
    rst = 1'b0; instr_ready = 1'b1;
    tick(10);
    checks++; if (req_q.size() < 1 || req_q[0] !== 8'h00 || got_q.size() < 1 || got_q[0] !== 24'h100000) begin
      errors++; $display("FAIL rm_restart got addr=%h instr=%h exp=00,100000", req_q[0], got_q[0]); end
    do_reset(8'hfe, 1, 1'b1);
    tick(8);
    checks++; if (got_q.size() < 3 || got_q[0] !== 24'h10fefe || got_q[1] !== 24'h10ffff || got_q[2] !== 24'h100000) begin
      errors++; $display("FAIL wrap n=%0d got=%h,%h,%h exp=10fefe,10ffff,100000", got_q.size(), got_q[0], got_q[1], got_q[2]); end
  endtask

  task automatic test_fetch_en();
    do_reset(8'h10, 3, 1'b1);
    tick(1);
    fetch_en = 1'b0;
    tick(8);
    checks++; if (got_q.size() != 1 || got_q[0] !== 24'h101010) begin errors++; $display("FAIL fe_inflight n=%0d got=%h exp=1,101010", got_q.size(), got_q[0]); end
    checks++; if (req_q.size() != 1 || pcen_q.size() != 1) begin errors++; $display("FAIL fe_blocked got req=%0d pc_en=%0d exp=1,1", req_q.size(), pcen_q.size()); end
    fetch_en = 1'b1;
    tick(6);
    checks++; if (req_q.size() < 2 || req_q[1] !== 8'h11) begin errors++; $display("FAIL fe_resume n=%0d got=%h exp=11", req_q.size(), req_q[1]); end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    inj_rvalid = 1'b0; inj_data = 16'h0; redir_target = 8'h0;
    pc_rst_val = 8'h0; lat_cfg = 1;
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_reset_mid_and_wrap();
    test_fetch_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Issues one instruction-memory read per PC value and pulses the PC advance.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake and flushes cleanly on a branch redirect.

Parameters:
- ADDR_W, 8, PC / instruction address width.
- INSTR_W, 16, instruction word width.
- DEPTH, 2, instruction FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- fetch_en  in  1  core run enable; 0 blocks new requests (in-flight data still accepted).
- pc_addr  in  ADDR_W  current PC value.
- pc_en  out  1  PC increment enable, one cycle per issued request.
- redirect  in  1  branch taken; high in the same cycle the PC overwrite is applied.
- imem_req  out  1  read request strobe, single cycle.
- imem_addr  out  ADDR_W  read address, valid while imem_req=1.
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after imem_req.
- imem_rdata  in  INSTR_W  read data.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  PC of head instruction.

Behaviour:
- Reset: the following all read 0:
  - state=IDLE
  - FIFO empty (count=0, rd/wr ptr 0)
  - imem_req, pc_en, instr_valid
  - instr, instr_pc (registered head)
- Instruction memory is reset by the same rst; rst mid-request abandons it with no stale response.
- Outstanding requests: at most 1.
- State IDLE:
  - issue = fetch_en & ~redirect & (count < DEPTH).
  - On issue: imem_req=1, imem_addr=pc_addr (combinational), pc_en=1 in the same cycle, pc_addr latched as req_pc, go WAIT.
  - imem_rvalid in IDLE is ignored.
- State WAIT:
  - imem_rvalid & ~redirect: push {imem_rdata, req_pc}, go IDLE.
  - No new request issues in the return cycle; minimum issue interval is 2 cycles.
  - redirect without rvalid: go DISCARD.
  - redirect with rvalid in the same cycle: data dropped, go IDLE.
- State DISCARD:
  - Wait for imem_rvalid, drop the data, go IDLE.
  - A further redirect in DISCARD stays in DISCARD.
- redirect (any state):
  - FIFO flushed (count=0, ptrs reset) at the clock edge.
  - instr_valid=0 next cycle.
  - A pop in the redirect cycle is still a completed handshake.
  - pc_en=0 and imem_req=0 during redirect.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Push when count=DEPTH cannot occur by construction.
  - instr_valid = (count != 0).
  - instr/instr_pc reflect the head entry and hold while valid & ~ready.
- Latency: pc_addr sampled at issue → instr_valid earliest 1 cycle after imem_rvalid (registered FIFO write).
- Wrap-around: the PC wrapping 0xFF→0x00 is transparent; instr_pc carries 0xFF then 0x00.
- fetch_en=0: no issue; in-flight completes normally; FIFO drains normally.

Test Plan:
- Straight-line fetch:
  - Stimulus: reset, pc starts 0x00, mem[n]=0x1000+n, 1-cycle memory, ready=1, fetch_en=1.
  - Required: instr/instr_pc pairs (0x1000,0x00),(0x1001,0x01),(0x1002,0x02) in order; pc_en pulses every 2 cycles.
- Backpressure:
  - Stimulus: ready=0 from start.
  - Required: FIFO fills to DEPTH=2 (PCs 0x00,0x01); imem_req stays 0 with pc at 0x02; instr held at 0x1000.
  - Then ready=1: both pop, fetch resumes at 0x02.
- Redirect during WAIT:
  - Stimulus: 3-cycle memory latency; redirect with pc overwrite to 0x40 one cycle after a request to 0x05.
  - Required: mem[0x05] data dropped; next imem_addr=0x40; first delivered instr_pc=0x40.
- Redirect coincident with rvalid and a full FIFO:
  - Stimulus: redirect in the same cycle as imem_rvalid while count=2.
  - Required: count=0 next cycle; instr_valid=0; no push; state IDLE.
- Reset mid-operation and PC wrap:
  - Stimulus: rst asserted during WAIT with FIFO non-empty.
  - Required: outputs 0 the next cycle, and fetch restarts at pc 0x00.
  - Separately, PC run from 0xFE: instr_pc sequence 0xFE, 0xFF, 0x00.
- fetch_en gating:
  - Stimulus: fetch_en dropped while WAIT.
  - Required: outstanding data still pushed; no further imem_req or pc_en until fetch_en=1.
